div_issue_ctrl: RTL and testbench

Control stage that sits directly upstream of the multi-cycle 64-cycle divider. It accepts DIV/DIVU/REM/REMU and their W forms from the EX stage and stalls EX while a divide is in flight. It resolves the RISC-V special cases (divide-by-zero, signed overflow) itself without issuing to the divider. It captures the divider's single-cycle result pulse, sign-extends W results, and holds the final value for writeback under a valid/ready handshake. It also supports pipeline flush.

---
 rtl/div_issue_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// Issue/control stage in front of the iterative 64-bit divider: resolves the RISC-V
// divide special cases locally, runs one divide at a time and holds the result for writeback.
module div_issue_ctrl #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [XLEN-1:0]  ex_src1,
    input  logic [XLEN-1:0]  ex_src2,
    input  logic             ex_is_w,
    input  logic [1:0]       ex_op,
    input  logic [TAG_W-1:0] ex_rd,
    input  logic             flush,
    output logic             div_in_valid,
    input  logic             div_in_ready,
    output logic [XLEN-1:0]  div_src1,
    output logic [XLEN-1:0]  div_src2,
    output logic             div_is_w,
    output logic [1:0]       div_aluctr,
    input  logic             div_out_valid,
    input  logic [XLEN-1:0]  div_result,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_rd,
    output logic [XLEN-1:0]  wb_result,
    output logic             busy
);

    localparam int unsigned WW = 32;
    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-WW+1){1'b1}}, {(WW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_live;
    logic [XLEN-1:0]   r_src1;
    logic [XLEN-1:0]   r_src2;
    logic              r_is_w;
    logic [1:0]        r_op;
    logic [TAG_W-1:0]  r_rd;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_capture;
    logic              w_signed;
    logic [XLEN-1:0]   w_eff_src1;
    logic [XLEN-1:0]   w_eff_src2;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_spec_res;

    function automatic logic [XLEN-1:0] sext_w(input logic [WW-1:0] v);
        return {{(XLEN-WW){v[WW-1]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext_w(input logic [WW-1:0] v);
        return {{(XLEN-WW){1'b0}}, v};
    endfunction

    // Effective operands and the special-case result, evaluated on the EX inputs
    always_comb begin
        w_signed   = ~ex_op[0];
        w_eff_src1 = ex_src1;
        w_eff_src2 = ex_src2;
        if (ex_is_w) begin
            w_eff_src1 = w_signed ? sext_w(ex_src1[WW-1:0]) : zext_w(ex_src1[WW-1:0]);
            w_eff_src2 = w_signed ? sext_w(ex_src2[WW-1:0]) : zext_w(ex_src2[WW-1:0]);
        end
        w_div_zero = (w_eff_src2 == '0);
        w_ovf      = w_signed && (w_eff_src1 == (ex_is_w ? MIN_W : MIN_D)) && (w_eff_src2 == '1);
        w_special  = w_div_zero || w_ovf;
        w_spec_res = '0;
        if (w_div_zero) begin
            w_spec_res = ex_op[1] ? w_eff_src1 : '1;
        end else if (w_ovf) begin
            w_spec_res = ex_op[1] ? '0 : w_eff_src1;
        end
        if (ex_is_w) begin
            w_spec_res = sext_w(w_spec_res[WW-1:0]);
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next       = r_state;
        ex_ready     = 1'b0;
        div_in_valid = 1'b0;
        wb_valid     = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                ex_ready = r_live && !flush;
                w_accept = ex_valid && r_live && !flush;
                if (w_accept) begin
                    w_next = w_special ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                div_in_valid = !flush;
                if (flush) begin
                    w_next = S_IDLE;
                end else if (div_in_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (div_out_valid) begin
                    w_capture = !flush;
                    w_next    = flush ? S_IDLE : S_DONE;
                end else if (flush) begin
                    w_next = S_DRAIN;
                end
            end
            // The divider cannot be aborted; swallow its result before reopening.
            S_DRAIN: begin
                if (div_out_valid) begin
                    w_next = S_IDLE;
                end
            end
            S_DONE: begin
                wb_valid = !flush;
                if (flush || wb_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src1   <= '0;
            r_src2   <= '0;
            r_is_w   <= 1'b0;
            r_op     <= 2'b00;
            r_rd     <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_src1 <= w_eff_src1;
                r_src2 <= w_eff_src2;
                r_is_w <= ex_is_w;
                r_op   <= ex_op;
                r_rd   <= ex_rd;
                if (w_special) begin
                    r_result <= w_spec_res;
                end
            end
            if (w_capture) begin
                r_result <= r_is_w ? sext_w(div_result[WW-1:0]) : div_result;
            end
        end
    end

    assign div_src1   = r_src1;
    assign div_src2   = r_src2;
    assign div_is_w   = r_is_w;
    assign div_aluctr = r_op;
    assign wb_rd      = r_rd;
    assign wb_result  = r_result;
    assign busy       = (r_state != S_IDLE);

    // A divider result is only legal while a divide is outstanding
    property p_no_stray_result;
        @(posedge clk) disable iff (!rst)
            div_out_valid |-> ((r_state == S_WAIT) || (r_state == S_DRAIN));
    endproperty
    a_no_stray_result: assert property (p_no_stray_result);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed vector table, multi-cycle flush/reset sequences and
// randomized ops checked against a RISC-V divide reference model with a latency-programmable divider.
`timescale 1ns/1ps
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid, ex_ready, ex_is_w, flush;
    logic [63:0] ex_src1, ex_src2;
    logic [1:0]  ex_op;
    logic [4:0]  ex_rd;
    logic        div_in_valid, div_in_ready, div_is_w, div_out_valid;
    logic [63:0] div_src1, div_src2, div_result;
    logic [1:0]  div_aluctr;
    logic        wb_valid, wb_ready, busy;
    logic [4:0]  wb_rd;
    logic [63:0] wb_result;

    always #5 clk = ~clk;

    div_issue_ctrl #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_is_w(ex_is_w), .ex_op(ex_op), .ex_rd(ex_rd), .flush(flush),
        .div_in_valid(div_in_valid), .div_in_ready(div_in_ready),
        .div_src1(div_src1), .div_src2(div_src2), .div_is_w(div_is_w), .div_aluctr(div_aluctr),
        .div_out_valid(div_out_valid), .div_result(div_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_result(wb_result),
        .busy(busy)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          issue_cnt = 0;
    int          iss_base = 0;
    int          lat_cfg = 66;
    int          div_cnt = 0;
    bit          rand_ready = 1'b0;
    logic [63:0] iss_src1, iss_src2, div_res_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics, straight from the ISA rules
    function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                            input logic w, input logic [1:0] op);
        logic [31:0] a32, b32, r32;
        logic [63:0] r64;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'h0)                                          r32 = op[1] ? a32 : 32'hFFFF_FFFF;
            else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = op[1] ? 32'h0 : a32;
            else if (op[0])                                            r32 = op[1] ? a32 % b32 : a32 / b32;
            else r32 = op[1] ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'h0)                                                     r64 = op[1] ? a : '1;
        else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1)         r64 = op[1] ? 64'h0 : a;
        else if (op[0])                                                     r64 = op[1] ? a % b : a / b;
        else r64 = op[1] ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
        return r64;
    endfunction

    function automatic bit is_special(input logic [63:0] a, input logic [63:0] b,
                                      input logic w, input logic [1:0] op);
        if (w) return (b[31:0] == 32'h0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'h0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    // Divider model: fixed latency per op, W results returned zero-extended
    initial begin : divider_model
        logic hs, w;
        logic [63:0] s1, s2;
        logic [1:0] op;
        div_out_valid = 1'b0;
        div_result    = '0;
        div_in_ready  = 1'b1;
        forever begin
            @(negedge clk);
            hs = div_in_valid && div_in_ready;
            s1 = div_src1; s2 = div_src2; w = div_is_w; op = div_aluctr;
            @(posedge clk);
            #1;
            div_out_valid = 1'b0;
            if (!rst) begin
                div_cnt = 0;
            end else if (hs) begin
                issue_cnt++;
                iss_src1  = s1;
                iss_src2  = s2;
                div_res_q = ref_div(s1, s2, w, op);
                if (w) div_res_q = {32'h0, div_res_q[31:0]};
                div_cnt = lat_cfg;
            end else if (div_cnt > 0) begin
                div_cnt--;
                if (div_cnt == 0) begin
                    div_out_valid = 1'b1;
                    div_result    = div_res_q;
                end
            end
            div_in_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic start_op(input string name, input logic [63:0] s1, input logic [63:0] s2,
                            input logic w, input logic [1:0] op, input logic [4:0] rd, output bit ok);
        int cyc = 0;
        @(negedge clk);
        while (!ex_ready && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        ok = ex_ready;
        if (!ok) begin
            check({name, " ex_ready timeout"}, 64'(ex_ready), 64'd1);
            return;
        end
        ex_src1 = s1; ex_src2 = s2; ex_is_w = w; ex_op = op; ex_rd = rd;
        ex_valid = 1'b1;
        iss_base = issue_cnt;
        @(posedge clk);
        #1 ex_valid = 1'b0;
    endtask

    task automatic wait_issue(input string name);
        int cyc = 0;
        while (issue_cnt == iss_base && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " issued"}, 64'(issue_cnt - iss_base), 64'd1);
    endtask

    task automatic run_op(input string name, input logic [63:0] s1, input logic [63:0] s2,
                          input logic w, input logic [1:0] op, input logic [4:0] rd,
                          input logic [63:0] exp, input bit exp_issue, input int hold);
        bit ok, seen, prev_pulse, stable;
        int cyc;
        start_op(name, s1, s2, w, op, rd, ok);
        if (!ok) return;
        cyc = 0; seen = 1'b0; prev_pulse = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (wb_valid) seen = 1'b1;
            else prev_pulse = div_out_valid;
        end
        if (!seen) begin
            check({name, " wb_valid timeout"}, 64'(wb_valid), 64'd1);
            return;
        end
        if (exp_issue) check({name, " wb one cycle after pulse"}, 64'(prev_pulse), 64'd1);
        else           check({name, " special latency"}, 64'(cyc), 64'd1);
        check({name, " wb_result"}, wb_result, exp);
        check({name, " wb_rd"}, 64'(wb_rd), 64'(rd));
        check({name, " ex_ready while done"}, 64'(ex_ready), 64'd0);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!wb_valid || wb_result !== exp || wb_rd !== rd) stable = 1'b0;
        end
        if (hold > 0) check({name, " held until wb_ready"}, 64'(stable), 64'd1);
        wb_ready = 1'b1;
        @(posedge clk);
        #1 wb_ready = 1'b0;
        @(negedge clk);
        check({name, " idle after wb"}, 64'({wb_valid, busy}), 64'd0);
        check({name, " issue count"}, 64'(issue_cnt - iss_base), 64'(exp_issue));
        if (exp_issue) begin
            if (w) check({name, " issued operands"}, {iss_src1[31:0], iss_src2[31:0]}, {s1[31:0], s2[31:0]});
            else   check({name, " issued operands"}, iss_src1 ^ {iss_src2[31:0], iss_src2[63:32]},
                         s1 ^ {s2[31:0], s2[63:32]});
        end
    endtask

    typedef struct {
        string       name;
        logic [63:0] s1, s2;
        logic        w;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [63:0] exp;
        bit          issue;
        int          hold;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input string name, input logic [63:0] s1, input logic [63:0] s2, input logic w,
                       input logic [1:0] op, input logic [4:0] rd, input logic [63:0] exp,
                       input bit issue, input int hold, input int lat);
        vec_t v;
        v.name = name; v.s1 = s1; v.s2 = s2; v.w = w; v.op = op; v.rd = rd;
        v.exp = exp; v.issue = issue; v.hold = hold; v.lat = lat;
        vecs.push_back(v);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'h0;
            1:       return 64'h1;
            2:       return '1;
            3:       return 64'h8000_0000_0000_0000;
            4:       return {32'($urandom), 32'h8000_0000};
            5:       return {32'($urandom), 32'hFFFF_FFFF};
            6:       return 64'($urandom_range(0, 100));
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    initial begin
        bit ok;
        int cyc, bad_ready, bad_wb;
        logic [63:0] s1, s2, exp;
        logic w;
        logic [1:0] op;
        ex_valid = 1'b0; ex_src1 = '0; ex_src2 = '0; ex_is_w = 1'b0; ex_op = 2'b00; ex_rd = '0;
        flush = 1'b0; wb_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ex_ready", 64'(ex_ready), 64'd0);
        check("reset outputs", 64'({busy, wb_valid, div_in_valid}), 64'd0);
        check("reset regs", wb_result | div_src1 | div_src2 | 64'(wb_rd), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post-reset ex_ready", 64'(ex_ready), 64'd1);

        add("DIV -7/2",      -64'sd7, 64'd2, 1'b0, 2'd0, 5'd5,  64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 5, 66);
        add("DIVU 5/0",      64'd5, 64'd0, 1'b0, 2'd1, 5'd6,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 5);
        add("REM 5/0",       64'd5, 64'd0, 1'b0, 2'd2, 5'd7,  64'd5, 1'b0, 2, 5);
        add("DIVW ovf",      64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 2'd0, 5'd8, 64'hFFFF_FFFF_8000_0000, 1'b0, 1, 5);
        add("REMW ovf",      64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 2'd2, 5'd9, 64'd0, 1'b0, 0, 5);
        add("DIVUW sext",    64'hFFFF_FFFE, 64'd1, 1'b1, 2'd1, 5'd10, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 0, 5);
        add("REMU 100/7",    64'd100, 64'd7, 1'b0, 2'd3, 5'd11, 64'd2, 1'b1, 0, 3);
        add("DIV ovf",       64'h8000_0000_0000_0000, '1, 1'b0, 2'd0, 5'd12, 64'h8000_0000_0000_0000, 1'b0, 0, 5);
        add("REM ovf",       64'h8000_0000_0000_0000, '1, 1'b0, 2'd2, 5'd13, 64'd0, 1'b0, 0, 5);
        add("REMW 7/-2",     64'h1234_5678_0000_0007, 64'h0000_0000_FFFF_FFFE, 1'b1, 2'd2, 5'd14, 64'd1, 1'b1, 0, 4);
        add("DIVUW by 0",    64'h8000_0000, 64'hABCD_0000_0000_0000, 1'b1, 2'd1, 5'd15, '1, 1'b0, 0, 5);
        add("REMUW by 0",    64'h8000_0000, 64'h0, 1'b1, 2'd3, 5'd16, 64'hFFFF_FFFF_8000_0000, 1'b0, 0, 5);
        add("DIV 1",         64'h0123_4567_89AB_CDEF, 64'd1, 1'b0, 2'd0, 5'd31, 64'h0123_4567_89AB_CDEF, 1'b1, 0, 1);
        foreach (vecs[i]) begin
            lat_cfg = vecs[i].lat;
            run_op(vecs[i].name, vecs[i].s1, vecs[i].s2, vecs[i].w, vecs[i].op, vecs[i].rd,
                   vecs[i].exp, vecs[i].issue, vecs[i].hold);
        end

        // Reset asserted while a divide is outstanding
        lat_cfg = 66;
        start_op("rst-wait", 64'd100, 64'd7, 1'b0, 2'd0, 5'd9, ok);
        wait_issue("rst-wait");
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst-wait state", 64'({busy, wb_valid, div_in_valid, ex_ready}), 64'd0);
        check("rst-wait regs", div_src1 | div_src2 | wb_result | 64'(wb_rd), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst-wait ex_ready after release", 64'(ex_ready), 64'd1);

        // Flush ten cycles into a divide: drain the pulse, then accept immediately
        lat_cfg = 30;
        start_op("flush-drain", 64'd1000, 64'd3, 1'b0, 2'd0, 5'd4, ok);
        wait_issue("flush-drain");
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush-drain flush cycle", 64'({ex_ready, wb_valid}), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        bad_ready = 0; bad_wb = 0; cyc = 0;
        @(negedge clk);
        while (!div_out_valid && cyc < 200) begin
            if (ex_ready) bad_ready++;
            if (wb_valid) bad_wb++;
            @(negedge clk);
            cyc++;
        end
        check("flush-drain pulse seen", 64'(div_out_valid), 64'd1);
        check("flush-drain ex_ready low while draining", 64'(bad_ready + 32'(ex_ready)), 64'd0);
        check("flush-drain no wb", 64'(bad_wb + 32'(wb_valid)), 64'd0);
        @(negedge clk);
        check("flush-drain ready after pulse", 64'({ex_ready, wb_valid}), 64'b10);
        ex_src1 = 64'd5; ex_src2 = 64'd0; ex_is_w = 1'b0; ex_op = 2'd1; ex_rd = 5'd3;
        ex_valid = 1'b1;
        @(posedge clk);
        #1 ex_valid = 1'b0;
        @(negedge clk);
        check("flush-drain next op wb", {wb_result[62:0], wb_valid}, '1);
        wb_ready = 1'b1;
        @(posedge clk);
        #1 wb_ready = 1'b0;

        // Flush in the same cycle as the divider pulse
        lat_cfg = 12;
        start_op("flush-pulse", 64'd77, 64'd5, 1'b0, 2'd0, 5'd2, ok);
        wait_issue("flush-pulse");
        cyc = 0;
        while (div_cnt != 1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush-pulse coincident", 64'({div_out_valid, busy, ex_ready, wb_valid}), 64'b1100);
        @(posedge clk);
        #1 flush = 1'b0;
        bad_wb = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wb_valid || busy || !ex_ready) bad_wb++;
        end
        check("flush-pulse straight to idle", 64'(bad_wb), 64'd0);

        // Flush beats wb_ready in DONE
        start_op("flush-done", 64'd5, 64'd0, 1'b0, 2'd2, 5'd1, ok);
        @(negedge clk);
        check("flush-done wb_valid", 64'(wb_valid), 64'd1);
        flush = 1'b1; wb_ready = 1'b1;
        #1;
        check("flush-done wb_valid masked", 64'(wb_valid), 64'd0);
        @(posedge clk);
        #1 begin flush = 1'b0; wb_ready = 1'b0; end
        @(negedge clk);
        check("flush-done idle", 64'({busy, wb_valid, ex_ready}), 64'b001);

        // Randomized ops against the reference model
        rand_ready = 1'b1;
        for (int k = 0; k < 150; k++) begin
            s1 = pick();
            s2 = pick();
            w  = 1'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            lat_cfg = $urandom_range(1, 66);
            exp = ref_div(s1, s2, w, op);
            run_op($sformatf("rnd%0d", k), s1, s2, w, op, 5'($urandom), exp,
                   !is_special(s1, s2, w, op), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
